// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: routes processor traffic to data memory or to a
// bank of output/input channel registers with change-detect interrupts.
module io_bridge #(
    parameter int NBITS = 8,
    parameter int NCH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NBITS-1:2]     cpu_addr,
    input  logic [NBITS-1:0]     cpu_wdata,
    input  logic                 cpu_we,
    output logic [NBITS-1:0]     cpu_rdata,
    output logic                 irq,
    output logic [NBITS-1:2]     mem_addr,
    output logic [NBITS-1:0]     mem_wdata,
    output logic                 mem_we,
    input  logic [NBITS-1:0]     mem_rdata,
    input  logic [NCH*NBITS-1:0] ch_in,
    output logic [NCH*NBITS-1:0] ch_out
);

    localparam int OFFW = NBITS - 3;
    localparam logic [OFFW-1:0] PEND_OFF = OFFW'(2 * NCH);
    localparam logic [OFFW-1:0] MASK_OFF = OFFW'(2 * NCH + 1);

    logic                 io;
    logic [OFFW-1:0]      offset;
    logic                 wr_pend;
    logic                 wr_mask;
    logic [NCH*NBITS-1:0] s1;
    logic [NCH*NBITS-1:0] s2;
    logic [NCH*NBITS-1:0] prev;
    logic [1:0]           cnt;
    logic                 arm_done;
    logic [NCH-1:0]       chg;
    logic [NCH-1:0]       pend;
    logic [NCH-1:0]       mask;
    logic [NBITS-1:0]     rd_val;
    logic                 sel_q;
    logic [NBITS-1:0]     io_q;

    assign io     = cpu_addr[NBITS-1];
    assign offset = cpu_addr[NBITS-2:2];

    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;
    assign mem_we    = cpu_we & ~io;

    assign wr_pend  = cpu_we & io & (offset == PEND_OFF);
    assign wr_mask  = cpu_we & io & (offset == MASK_OFF);
    assign arm_done = (cnt == 2'd3);
    assign irq      = |(pend & mask);

    always_comb begin
        chg = '0;
        for (int i = 0; i < NCH; i++)
            chg[i] = arm_done & (s2[i*NBITS +: NBITS] != prev[i*NBITS +: NBITS]);
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (offset == OFFW'(i))       rd_val = ch_out[i*NBITS +: NBITS];
            if (offset == OFFW'(NCH + i)) rd_val = s2[i*NBITS +: NBITS];
        end
        if (offset == PEND_OFF) rd_val[NCH-1:0] = pend;
        if (offset == MASK_OFF) rd_val[NCH-1:0] = mask;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, e.g. s2 takes the old s1 rather than ch_in.
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_out <= '0;
            s1     <= '0;
            s2     <= '0;
            prev   <= '0;
            cnt    <= 2'd0;
            pend   <= '0;
            mask   <= '0;
            sel_q  <= 1'b0;
            io_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (cpu_we && io && offset == OFFW'(i))
                    ch_out[i*NBITS +: NBITS] <= cpu_wdata;
            s1   <= ch_in;
            s2   <= s1;
            prev <= s2;
            if (!arm_done) cnt <= cnt + 2'd1;
            // A change arriving with a clear of the same bit keeps the bit set.
            pend <= chg | (pend & ~({NCH{wr_pend}} & cpu_wdata[NCH-1:0]));
            if (wr_mask) mask <= cpu_wdata[NCH-1:0];
            sel_q <= io;
            io_q  <= rd_val;
        end
    end

    assign cpu_rdata = sel_q ? io_q : mem_rdata;

endmodule

// File: tb/tb_io_bridge.sv
// Directed scoreboard bench for io_bridge (NBITS=8, NCH=4): expectations are
// queued as stimulus is driven and popped when the DUT output is sampled.
module tb_io_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:2]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        irq;
    logic [7:2]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [31:0] ch_in;
    logic [31:0] ch_out;

    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  d;

    io_bridge #(.NBITS(8), .NCH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .irq       (irq),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .ch_in     (ch_in),
        .ch_out    (ch_out)
    );

    always #5 clock = ~clock;

    task automatic push(input logic [31:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s observed %h with no expected value queued", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [7:2] a, input logic [7:0] v);
        cpu_addr  = a;
        cpu_wdata = v;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:2] a, output logic [7:0] v);
        cpu_addr = a;
        cpu_we   = 1'b0;
        tick();
        v = cpu_rdata;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_addr  = 6'h00;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        mem_rdata = 8'h9E;
        ch_in     = 32'h0;
        tick();
        tick();
        push(32'h9E); check("reset_rdata_mem", cpu_rdata);
        push(32'h0);  check("reset_irq", irq);

        // Nonzero inputs right after reset must not register as changes.
        reset = 1'b0;
        ch_in = {4{8'hA5}};
        repeat (10) tick();
        push(32'h0); bus_read(6'h28, d); check("arm_pend_zero", d);
        push(32'h0); check("arm_irq_zero", irq);
        push(32'h0); check("arm_ch_out_zero", ch_out);

        // Output register write then read-back.
        cpu_addr = 6'h22; cpu_wdata = 8'h3C; cpu_we = 1'b1;
        #1;
        push(32'h0); check("out_mem_we", mem_we);
        tick();
        cpu_we = 1'b0;
        push(32'h3C); check("out_ch_out", ch_out[23:16]);
        push(32'h0);  check("out_same_cycle_old", cpu_rdata);
        push(32'h3C); bus_read(6'h22, d); check("out_readback", d);

        // Memory pass-through.
        cpu_addr = 6'h05; cpu_wdata = 8'h77; cpu_we = 1'b1;
        #1;
        push(32'h1);  check("mem_we", mem_we);
        push(32'h05); check("mem_addr", mem_addr);
        push(32'h77); check("mem_wdata", mem_wdata);
        tick();
        cpu_we = 1'b0;
        mem_rdata = 8'h77;
        push(32'h77); bus_read(6'h05, d); check("mem_read", d);
        push(32'h003C0000); check("mem_no_io_change", ch_out);

        // Unmapped offset and read-only IN.
        bus_write(6'h2A, 8'hFF);
        push(32'h0);  bus_read(6'h2A, d); check("unmapped_read", d);
        bus_write(6'h25, 8'hFF);
        push(32'hA5); bus_read(6'h25, d); check("in1_read", d);
        push(32'h003C0000); check("in_write_ignored", ch_out);

        // Interrupt path: mask channel 1, start from a clean pending register.
        bus_write(6'h29, 8'h02);
        ch_in = 32'h0;
        repeat (4) tick();
        bus_write(6'h28, 8'hFF);
        push(32'h0); bus_read(6'h28, d); check("pend_cleared", d);
        push(32'h0); check("irq_cleared", irq);

        ch_in[15:8] = 8'h01;
        tick();
        tick();
        push(32'h0); check("irq_after_e1", irq);
        tick();
        push(32'h1); check("irq_after_e2", irq);
        push(32'h02); bus_read(6'h28, d); check("pend_ch1", d);

        ch_in[31:24] = 8'h80;
        repeat (3) tick();
        push(32'h1);  check("irq_ch3_unmasked", irq);
        push(32'h0A); bus_read(6'h28, d); check("pend_ch1_ch3", d);

        bus_write(6'h28, 8'h02);
        push(32'h0);  check("irq_after_w1c", irq);
        push(32'h08); bus_read(6'h28, d); check("pend_after_w1c", d);

        // Clear of bit 1 lands on the same edge that sets it again.
        ch_in[15:8] = 8'h03;
        tick();
        tick();
        bus_write(6'h28, 8'h02);
        push(32'h0A); bus_read(6'h28, d); check("set_wins", d);
        push(32'h1);  check("set_wins_irq", irq);

        // Fill all pending bits, unmask all, then reset mid-read.
        ch_in[7:0]   = 8'h11;
        ch_in[23:16] = 8'h22;
        repeat (3) tick();
        bus_write(6'h29, 8'h0F);
        push(32'h0F); bus_read(6'h28, d); check("pend_all", d);
        push(32'h1);  check("irq_all", irq);

        cpu_addr  = 6'h22;
        mem_rdata = 8'hC3;
        reset     = 1'b1;
        ch_in     = {4{8'h5A}};
        tick();
        reset = 1'b0;
        push(32'h0);  check("rst_irq", irq);
        push(32'hC3); check("rst_read_discarded", cpu_rdata);
        push(32'h0);  check("rst_ch_out", ch_out);

        bus_write(6'h29, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            push(32'h0); check("rearm_irq", irq);
            tick();
        end
        push(32'h0); bus_read(6'h28, d); check("rearm_pend", d);

        // Detection still works after re-arming.
        ch_in[23:16] = 8'h77;
        repeat (3) tick();
        push(32'h1);  check("post_rearm_irq", irq);
        push(32'h04); bus_read(6'h28, d); check("post_rearm_pend", d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
